fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline; owns the architectural fetch PC.
- Issues word requests to instruction memory over a req/ready + rvalid interface with at most one request outstanding.
- Presents the fetched instruction, its PC and PC+4 to the IF/ID pipeline register.
- Handles hazard-unit stalls and execute-stage redirects (branch/jump), including discard of stale in-flight responses.

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bundle for the fetch stage
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with single outstanding imem request
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Stall_F,
  input  logic                 PCSrc_E,
  input  logic [31:0]          PCTarget_E,
  fetch_stage_if.master        imem,
  output logic [31:0]          Instr_F,
  output logic [31:0]          PC_F,
  output logic [31:0]          PCPlus4_F,
  output logic                 Valid_F
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_KILL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pend_pc;
  logic        out_v;
  logic [31:0] out_instr, out_pc;
  logic        accept, load, consume;
  logic [1:0]  unused_tgt_lsb;

  assign unused_tgt_lsb = PCTarget_E[1:0];

  // Issue only when the output slot is free or drains this cycle, so a load never clobbers it.
  assign imem.imem_req  = !rst && (state_q == S_FETCH) && (!out_v || !Stall_F);
  assign imem.imem_addr = pc_q;

  assign accept  = imem.imem_req && imem.imem_ready;
  assign load    = (state_q == S_WAIT) && imem.imem_rvalid && !PCSrc_E;
  assign consume = out_v && !Stall_F;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (accept) state_d = PCSrc_E ? S_KILL : S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) state_d = S_FETCH;
        else if (PCSrc_E)     state_d = S_KILL;
      end
      S_KILL: begin
        if (imem.imem_rvalid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pend_pc   <= RESET_PC;
      out_v     <= 1'b0;
      out_instr <= NOP_INSTR;
      out_pc    <= 32'h0;
    end else if (PCSrc_E) begin
      pc_q  <= {PCTarget_E[31:2], 2'b00};
      out_v <= 1'b0;
    end else begin
      if (accept) begin
        pend_pc <= pc_q;
        pc_q    <= pc_q + 32'd4;
      end
      if (load) begin
        out_instr <= imem.imem_rdata;
        out_pc    <= pend_pc;
        out_v     <= 1'b1;
      end else if (consume) begin
        out_v <= 1'b0;
      end
    end
  end

  assign Valid_F   = out_v;
  assign Instr_F   = out_v ? out_instr : NOP_INSTR;
  assign PC_F      = out_pc;
  assign PCPlus4_F = out_pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        Stall_F, PCSrc_E;
  logic [31:0] PCTarget_E;
  logic [31:0] Instr_F, PC_F, PCPlus4_F;
  logic        Valid_F;

  fetch_stage_if imem();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h13)) dut (
    .clk(clk), .rst(rst), .Stall_F(Stall_F), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
    .imem(imem), .Instr_F(Instr_F), .PC_F(PC_F), .PCPlus4_F(PCPlus4_F), .Valid_F(Valid_F)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t  sb_q[$];
  mreq_t mem_q[$];
  int    checks = 0, errors = 0;
  int    cyc = 0, lat = 1;
  logic  mem_ready = 1'b1, inject = 1'b0;
  logic  s_req, s_acc, s_valid, s_rv;
  logic [31:0] s_addr, s_pc, s_instr, s_p4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory, sample outputs, score, then advance to the next negedge.
  task automatic cycle();
    imem.imem_ready = mem_ready;
    if (inject) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = 32'hDEAD_BEEF;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = 32'hA0 + mem_q[0].addr;
      mem_q.delete(0);
    end else begin
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = 32'h0;
    end
    #1;
    s_req = imem.imem_req;   s_addr  = imem.imem_addr; s_rv = imem.imem_rvalid;
    s_valid = Valid_F;       s_pc    = PC_F;
    s_instr = Instr_F;       s_p4    = PCPlus4_F;
    s_acc = s_req && mem_ready;
    if (s_valid) begin
      if (sb_q.size() == 0) chk("sb_unexpected_valid", sb_q.size(), 1);
      else begin
        chk("sb_pc", s_pc, sb_q[0].pc);
        chk("sb_instr", s_instr, sb_q[0].instr);
        chk("sb_pcplus4", s_p4, sb_q[0].pc + 32'd4);
        if (!Stall_F) sb_q.delete(0);
      end
    end else begin
      chk("nop_instr", s_instr, 32'h13);
    end
    if (s_acc) begin
      mem_q.push_back('{s_addr, cyc + lat});
      sb_q.push_back('{s_addr, 32'hA0 + s_addr});
    end
    if (PCSrc_E) sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; Stall_F = 1'b0; PCSrc_E = 1'b0; PCTarget_E = 32'h0;
    imem.imem_ready = 1'b1; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_valid", Valid_F, 0);
    chk("rst_instr", Instr_F, 32'h13);
    chk("rst_pc", PC_F, 0);
    chk("rst_pcplus4", PCPlus4_F, 4);
    chk("rst_req", imem.imem_req, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("seq_req", s_req, (i % 2 == 0));
      if (i % 2 == 0) chk("seq_addr", s_addr, 2 * i);
      chk("seq_valid", s_valid, (i >= 2 && i % 2 == 0));
      if (i >= 2 && i % 2 == 0) chk("seq_pc", s_pc, 2 * (i - 2));
    end

    Stall_F = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_valid", s_valid, 1);
      chk("stall_pc", s_pc, 32'h8);
      chk("stall_instr", s_instr, 32'hA8);
      chk("stall_req", s_req, 0);
    end
    Stall_F = 1'b0;
    cycle();
    chk("unstall_acc", s_acc, 1);
    chk("unstall_addr", s_addr, 32'hC);

    cycle();
    lat = 2;
    cycle();
    chk("kill_req_addr", s_addr, 32'h10);
    lat = 1;
    PCSrc_E = 1'b1; PCTarget_E = 32'h103;
    cycle();
    PCSrc_E = 1'b0;
    chk("kill_wait_rv", s_rv, 0);
    chk("kill_wait_valid", s_valid, 0);
    cycle();
    chk("kill_stale_rv", s_rv, 1);
    chk("kill_req", s_req, 0);
    chk("kill_valid", s_valid, 0);
    cycle();
    chk("kill_after_req", s_req, 1);
    chk("kill_after_addr", s_addr, 32'h100);
    chk("kill_after_valid", s_valid, 0);
    cycle();
    cycle();
    chk("tgt_pc", s_pc, 32'h100);
    chk("tgt_instr", s_instr, 32'h1A0);
    chk("tgt_next_addr", s_addr, 32'h104);

    PCSrc_E = 1'b1; PCTarget_E = 32'h200;
    cycle();
    PCSrc_E = 1'b0;
    chk("rdir_rv_same", s_rv, 1);
    cycle();
    chk("rdir_req", s_req, 1);
    chk("rdir_addr", s_addr, 32'h200);
    chk("rdir_valid", s_valid, 0);
    cycle();

    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin PCSrc_E = 1'b1; PCTarget_E = 32'h40; end
      cycle();
      PCSrc_E = 1'b0;
      chk("nready_req", s_req, 1);
      chk("nready_addr", s_addr, (i < 3) ? 32'h204 : 32'h40);
    end
    mem_ready = 1'b1;
    cycle();
    chk("ready_acc", s_acc, 1);
    chk("ready_addr", s_addr, 32'h40);
    cycle();

    PCSrc_E = 1'b1; PCTarget_E = 32'hFFFF_FFFC;
    cycle();
    PCSrc_E = 1'b0;
    chk("wrap_consume_pc", s_pc, 32'h40);
    chk("wrap_stale_addr", s_addr, 32'h44);
    cycle();
    chk("wrap_kill_req", s_req, 0);
    chk("wrap_kill_rv", s_rv, 1);
    cycle();
    chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
    cycle();
    lat = 2;
    cycle();
    chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", s_p4, 32'h0);
    chk("wrap_instr", s_instr, 32'h9C);
    chk("wrap_next_addr", s_addr, 32'h0);
    lat = 1;

    #2; rst = 1'b1; #1;
    chk("midrst_valid", Valid_F, 0);
    chk("midrst_addr", imem.imem_addr, 32'h0);
    chk("midrst_req", imem.imem_req, 0);
    chk("midrst_instr", Instr_F, 32'h13);
    chk("midrst_pcplus4", PCPlus4_F, 4);
    mem_q.delete();
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    chk("post_rst_acc", s_acc, 1);
    chk("post_rst_addr", s_addr, 32'h0);
    cycle();
    cycle();
    chk("post_rst_valid", s_valid, 1);
    chk("post_rst_pc", s_pc, 32'h0);
    chk("post_rst_instr", s_instr, 32'hA0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
